fpdiv_round: RTL and testbench

- Post-division normalize/round/pack stage placed directly downstream of the FP32 divider's iterative quotient core.
- Consumes the raw quotient significand, the biased exponent, the sign, and the final remainder status (sign, zero) from the divider.
- Produces the IEEE-754 binary32 quotient under round-to-nearest-even (RNE) or round-toward-zero (RZ).
- Two-stage valid/ready pipeline with full backpressure.

---
 rtl/fpdiv_round.sv | 106 ++++++++++
 tb/tb_fpdiv_round.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpdiv_round.sv
// fpdiv_round: normalizes, rounds (RNE/RZ) and packs the FP32 divider quotient in a 2-stage valid/ready pipe
module fpdiv_round #(
    parameter logic [31:0] NAN_VAL = 32'h7FC00000,
    parameter int          EXP_W   = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             round_mode,
    input  logic             q_sign,
    input  logic [EXP_W-1:0] q_exp,
    input  logic [25:0]      q_mant,
    input  logic             rem_zero,
    input  logic             rem_sign,
    input  logic [1:0]       cls,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      quotient,
    output logic [2:0]       flags
);
    localparam logic signed [EXP_W:0] EMAX = (EXP_W+1)'(255);
    localparam logic signed [EXP_W:0] EMIN = '0;

    logic s1_valid, s2_valid, s1_en, s2_en;
    logic s1_sign, s1_rz, s1_g, s1_sticky;
    logic [1:0] s1_cls;
    logic [22:0] s1_frac;
    logic signed [EXP_W:0] s1_exp;

    logic [25:0] q_adj;
    logic sticky0, n_g, n_sticky;
    logic [22:0] n_frac;
    logic signed [EXP_W:0] n_exp;

    logic inc, ovf, unf;
    logic [23:0] sum;
    logic signed [EXP_W:0] exp_r;
    logic [31:0] n_q;
    logic [2:0] n_f;

    assign s2_en     = !s2_valid || out_ready;
    assign s1_en     = !s1_valid || s2_en;
    assign in_ready  = s1_en;
    assign out_valid = s2_valid;

    // Undo a quotient overestimate, then align to a 1.f significand with guard and sticky
    always_comb begin
        q_adj    = q_mant - {25'b0, rem_sign};
        sticky0  = rem_sign | !rem_zero;
        n_frac   = q_adj[25] ? q_adj[24:2] : q_adj[23:1];
        n_g      = q_adj[25] ? q_adj[1] : q_adj[0];
        n_sticky = sticky0 | (q_adj[25] & q_adj[0]);
        n_exp    = {q_exp[EXP_W-1], q_exp} - {{EXP_W{1'b0}}, !q_adj[25]};
    end

    // Stage 1 register: normalized fields plus pass-through sign/class/mode
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (s1_en) begin
            s1_valid  <= in_valid;
            s1_sign   <= q_sign;
            s1_rz     <= round_mode;
            s1_cls    <= cls;
            s1_exp    <= n_exp;
            s1_frac   <= n_frac;
            s1_g      <= n_g;
            s1_sticky <= n_sticky;
        end
    end

    // Round, detect range limits and pick the packed result; special classes override everything
    always_comb begin
        inc   = !s1_rz & s1_g & (s1_sticky | s1_frac[0]);
        sum   = {1'b0, s1_frac} + {23'b0, inc};
        exp_r = s1_exp + {{EXP_W{1'b0}}, sum[23]};
        ovf   = exp_r >= EMAX;
        unf   = exp_r <= EMIN;
        n_q   = s1_cls == 2'b01 ? {s1_sign, 31'h0} :
                s1_cls == 2'b10 ? {s1_sign, 8'hFF, 23'h0} :
                s1_cls == 2'b11 ? NAN_VAL :
                ovf ? (s1_rz ? {s1_sign, 31'h7F7FFFFF} : {s1_sign, 8'hFF, 23'h0}) :
                unf ? {s1_sign, 31'h0} :
                {s1_sign, exp_r[7:0], sum[22:0]};
        n_f   = s1_cls != 2'b00 ? 3'b000 :
                ovf ? 3'b101 :
                unf ? 3'b011 :
                {2'b00, s1_g | s1_sticky};
    end

    // Stage 2 register: output is held while the consumer stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            quotient <= '0;
            flags    <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                quotient <= n_q;
                flags    <= n_f;
            end
        end
    end
endmodule

// File: tb/tb_fpdiv_round.sv
// tb_fpdiv_round: randomized and directed checks of fpdiv_round against a value-level rounding model
module tb_fpdiv_round;
    logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, round_mode = 1'b0, q_sign = 1'b0;
    logic rem_zero = 1'b1, rem_sign = 1'b0, out_ready = 1'b1;
    logic [9:0] q_exp = 10'd127;
    logic [25:0] q_mant = 26'h2000000;
    logic [1:0] cls = 2'b00;
    logic in_ready, out_valid;
    logic [31:0] quotient;
    logic [2:0] flags;

    int pass_cnt = 0, total_cnt = 0;
    logic [34:0] pend_q[$], want_q[$], got_q[$];
    bit acc;

    typedef struct packed {
        logic rm; logic s; logic [9:0] e; logic [25:0] m;
        logic rz; logic rs; logic [1:0] c; logic [31:0] q; logic [2:0] f;
    } vec_t;

    fpdiv_round dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .round_mode(round_mode), .q_sign(q_sign), .q_exp(q_exp), .q_mant(q_mant),
        .rem_zero(rem_zero), .rem_sign(rem_sign), .cls(cls), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .flags(flags)
    );

    always #5 clk = ~clk;

    // Rounds the exact value (q_mant - rem_sign) * 2^-25 (+ a tail when the remainder is nonzero)
    function automatic logic [34:0] model(input logic rm, input logic s, input logic [9:0] qe,
                                          input logic [25:0] qm, input logic rz, input logic rs,
                                          input logic [1:0] c);
        longint n, kept, r, half;
        int sh, e;
        bit above, inexact, up;
        if (c == 2'b01) return {s, 31'h0, 3'b000};
        if (c == 2'b10) return {s, 8'hFF, 23'h0, 3'b000};
        if (c == 2'b11) return {32'h7FC00000, 3'b000};
        n = longint'(qm) - longint'(rs);
        above = rs || !rz;
        sh = (n >= (longint'(1) << 25)) ? 2 : 1;
        e = int'($signed(qe)) - (sh == 1 ? 1 : 0);
        kept = n >> sh;
        r = n - (kept << sh);
        half = longint'(1) << (sh - 1);
        inexact = (r != 0) || above;
        up = !rm && (r > half || (r == half && (above || kept[0])));
        kept = kept + (up ? 1 : 0);
        if (kept == (longint'(1) << 24)) begin
            kept = longint'(1) << 23;
            e++;
        end
        if (e >= 255) return {rm ? {s, 31'h7F7FFFFF} : {s, 8'hFF, 23'h0}, 3'b101};
        if (e <= 0) return {s, 31'h0, 3'b011};
        return {s, 8'(e), 23'(kept), 2'b00, inexact};
    endfunction

    task automatic tick;
        @(negedge clk);
        acc = in_valid && in_ready && !reset;
        if (reset) begin
            pend_q.delete();
        end else begin
            if (acc) pend_q.push_back(model(round_mode, q_sign, q_exp, q_mant, rem_zero, rem_sign, cls));
            if (out_valid && out_ready) begin
                got_q.push_back({quotient, flags});
                want_q.push_back(pend_q.size() != 0 ? pend_q.pop_front() : 35'h0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic rm, input logic s, input logic [9:0] e, input logic [25:0] m,
                          input logic rz, input logic rs, input logic [1:0] c);
        round_mode = rm; q_sign = s; q_exp = e; q_mant = m; rem_zero = rz; rem_sign = rs; cls = c;
    endtask

    task automatic send_one(output logic [31:0] q, output logic [2:0] f, output int lat);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        q = quotient;
        f = flags;
        tick();
    endtask

    task automatic clear_queues;
        pend_q.delete(); want_q.delete(); got_q.delete();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (quotient !== 32'h0) $display("FAIL reset_quotient got %h want 0", quotient); else pass_cnt++;
        total_cnt++; if (flags !== 3'b000) $display("FAIL reset_flags got %b want 000", flags); else pass_cnt++;
    endtask

    task automatic test_basic;
        logic [31:0] q;
        logic [2:0] f;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_op(1'b0, 1'b0, i == 0 ? 10'd127 : 10'd128, i == 0 ? 26'h2000000 : 26'h1000000, 1'b1, 1'b0, 2'b00);
            send_one(q, f, lat);
            total_cnt++; if (q !== 32'h3F800000) $display("FAIL basic%0d_quotient got %h want 3f800000", i, q); else pass_cnt++;
            total_cnt++; if (f !== 3'b000) $display("FAIL basic%0d_flags got %b want 000", i, f); else pass_cnt++;
            total_cnt++; if (lat !== 2) $display("FAIL basic%0d_latency got %0d want 2", i, lat); else pass_cnt++;
        end
    endtask

    task automatic test_round;
        vec_t v[15];
        logic [31:0] q;
        logic [2:0] f;
        int lat;
        v[0]  = '{1'b0, 1'b0, 10'd127, 26'h2000002, 1'b1, 1'b0, 2'b00, 32'h3F800000, 3'b001};
        v[1]  = '{1'b0, 1'b0, 10'd127, 26'h2000002, 1'b0, 1'b0, 2'b00, 32'h3F800001, 3'b001};
        v[2]  = '{1'b1, 1'b0, 10'd127, 26'h2000003, 1'b1, 1'b0, 2'b00, 32'h3F800000, 3'b001};
        v[3]  = '{1'b0, 1'b0, 10'd127, 26'h2000004, 1'b0, 1'b1, 2'b00, 32'h3F800001, 3'b001};
        v[4]  = '{1'b0, 1'b0, 10'd127, 26'h3FFFFFE, 1'b1, 1'b0, 2'b00, 32'h40000000, 3'b001};
        v[5]  = '{1'b0, 1'b0, 10'd255, 26'h2000000, 1'b1, 1'b0, 2'b00, 32'h7F800000, 3'b101};
        v[6]  = '{1'b1, 1'b0, 10'd255, 26'h2000000, 1'b1, 1'b0, 2'b00, 32'h7F7FFFFF, 3'b101};
        v[7]  = '{1'b0, 1'b0, 10'd0,   26'h2000000, 1'b1, 1'b0, 2'b00, 32'h00000000, 3'b011};
        v[8]  = '{1'b0, 1'b0, 10'd127, 26'h2000000, 1'b1, 1'b0, 2'b11, 32'h7FC00000, 3'b000};
        v[9]  = '{1'b0, 1'b1, 10'd127, 26'h2000000, 1'b1, 1'b0, 2'b01, 32'h80000000, 3'b000};
        v[10] = '{1'b0, 1'b1, 10'd127, 26'h2000000, 1'b1, 1'b0, 2'b10, 32'hFF800000, 3'b000};
        v[11] = '{1'b0, 1'b0, 10'd254, 26'h3FFFFFE, 1'b1, 1'b0, 2'b00, 32'h7F800000, 3'b101};
        v[12] = '{1'b0, 1'b0, 10'd1,   26'h1000000, 1'b1, 1'b0, 2'b00, 32'h00000000, 3'b011};
        v[13] = '{1'b1, 1'b1, 10'd3,   26'h3FFFFFF, 1'b0, 1'b0, 2'b00, 32'h81FFFFFF, 3'b001};
        v[14] = '{1'b0, 1'b1, 10'h3FF, 26'h2000000, 1'b1, 1'b0, 2'b00, 32'h80000000, 3'b011};
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            set_op(v[i].rm, v[i].s, v[i].e, v[i].m, v[i].rz, v[i].rs, v[i].c);
            send_one(q, f, lat);
            total_cnt++; if (q !== v[i].q) $display("FAIL round%0d_quotient got %h want %h", i, q, v[i].q); else pass_cnt++;
            total_cnt++; if (f !== v[i].f) $display("FAIL round%0d_flags got %b want %b", i, f, v[i].f); else pass_cnt++;
        end
    endtask

    task automatic test_backpressure;
        logic [34:0] held;
        int i = 0;
        clear_queues();
        out_ready = 1'b0;
        held = '0;
        for (int c = 0; c < 3; c++) begin
            set_op(1'b0, i[0], 10'(100 + i), 26'h2000000 + 26'(i * 9), 1'b0, 1'b0, 2'b00);
            in_valid = 1'b1;
            tick();
            if (acc) i++;
            if (c == 1) held = {quotient, flags};
        end
        total_cnt++; if (i !== 2) $display("FAIL bp_accepts got %0d want 2", i); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %b want 0", in_ready); else pass_cnt++;
        total_cnt++; if ({quotient, flags} !== held) $display("FAIL bp_hold got %h want %h", {quotient, flags}, held); else pass_cnt++;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && i < 4; c++) begin
            set_op(1'b0, i[0], 10'(100 + i), 26'h2000000 + 26'(i * 9), 1'b0, 1'b0, 2'b00);
            in_valid = 1'b1;
            tick();
            if (acc) i++;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        total_cnt++; if (got_q.size() !== 4) $display("FAIL bp_count got %0d want 4", got_q.size()); else pass_cnt++;
        for (int k = 0; k < got_q.size(); k++) begin
            total_cnt++; if (got_q[k] !== want_q[k]) $display("FAIL bp_order%0d got %h want %h", k, got_q[k], want_q[k]); else pass_cnt++;
        end
    endtask

    task automatic test_reset_midflight;
        logic [31:0] q;
        logic [2:0] f;
        int lat, seen = 0;
        clear_queues();
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_op(1'b0, 1'b0, 10'd130, 26'h2000010, 1'b1, 1'b0, 2'b00);
        tick();
        set_op(1'b0, 1'b1, 10'd120, 26'h2800000, 1'b1, 1'b0, 2'b00);
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_reset_out_valid got %b want 0", out_valid); else pass_cnt++;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (out_valid) seen++;
        end
        total_cnt++; if (seen !== 0 || got_q.size() !== 0) $display("FAIL mid_reset_ghost got %0d/%0d want 0/0", seen, got_q.size()); else pass_cnt++;
        set_op(1'b0, 1'b0, 10'd127, 26'h2000000, 1'b1, 1'b0, 2'b00);
        send_one(q, f, lat);
        total_cnt++; if (q !== 32'h3F800000) $display("FAIL mid_reset_next got %h want 3f800000", q); else pass_cnt++;
        total_cnt++; if (lat !== 2) $display("FAIL mid_reset_latency got %0d want 2", lat); else pass_cnt++;
    endtask

    task automatic test_random;
        int n = 0;
        logic [25:0] m;
        logic rz, rs;
        clear_queues();
        for (int c = 0; c < 3000 && n < 300; c++) begin
            m = ($urandom % 2) ? {1'b1, 25'($urandom)} : {2'b01, 24'($urandom)};
            if ($urandom % 4 == 0) m[2:0] = 3'($urandom);
            rz = ($urandom % 3 == 0);
            rs = !rz && ($urandom % 2 == 1) && m != 26'h1000000;
            set_op(1'($urandom), 1'($urandom), 10'(int'($urandom_range(0, 275)) - 6), m, rz, rs,
                   ($urandom % 8 == 0) ? 2'($urandom) : 2'b00);
            in_valid = ($urandom % 4 != 0);
            out_ready = ($urandom % 4 != 0);
            tick();
            if (acc) n++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        total_cnt++; if (got_q.size() !== n) $display("FAIL rand_count got %0d want %0d", got_q.size(), n); else pass_cnt++;
        for (int k = 0; k < got_q.size(); k++) begin
            total_cnt++; if (got_q[k] !== want_q[k]) $display("FAIL rand%0d got %h want %h", k, got_q[k], want_q[k]); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
